// File: rtl/dpll_lock_if.sv
// Handshake bundle between the phase detector / loop filter and the
// DPLL lock controller.
interface dpll_lock_if;
  logic        enable;
  logic        error_valid;
  logic [1:0]  margin_zone;
  logic        missing_pulse;
  logic [1:0]  state;
  logic        locked;
  logic        nco_freeze;
  logic [3:0]  kp_shift;
  logic [3:0]  ki_shift;
  logic        lock_acquired;
  logic        lock_lost;
  logic [15:0] acq_cycles;

  modport master (
    output enable,
    output error_valid,
    output margin_zone,
    output missing_pulse,
    input  state,
    input  locked,
    input  nco_freeze,
    input  kp_shift,
    input  ki_shift,
    input  lock_acquired,
    input  lock_lost,
    input  acq_cycles
  );

  modport slave (
    input  enable,
    input  error_valid,
    input  margin_zone,
    input  missing_pulse,
    output state,
    output locked,
    output nco_freeze,
    output kp_shift,
    output ki_shift,
    output lock_acquired,
    output lock_lost,
    output acq_cycles
  );
endinterface

// File: rtl/dpll_lock_controller.sv
// DPLL lock sequencer: acquire, track and coast (holdover) with
// gain scheduling, lock/unlock events and acquisition time.
module dpll_lock_controller #(
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 8,
  parameter int HOLD_MISSING = 4,
  parameter int HOLD_TIMEOUT = 4096,
  parameter int ACQ_KP_SHIFT = 2,
  parameter int ACQ_KI_SHIFT = 6,
  parameter int TRK_KP_SHIFT = 4,
  parameter int TRK_KI_SHIFT = 10
) (
  input  logic       clk,
  input  logic       reset,
  dpll_lock_if.slave bus
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int MW = $clog2(HOLD_MISSING + 1);
  localparam int HW = $clog2(HOLD_TIMEOUT);

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(HOLD_MISSING - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ACQ  = 2'b01;
  localparam logic [1:0] S_TRK  = 2'b10;
  localparam logic [1:0] S_HOLD = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   atmr_q, atmr_d;
  logic [15:0]   acq_cyc_q, acq_cyc_d;
  logic          lacq_q, lacq_d;
  logic          llost_q, llost_d;
  logic          locked_q, locked_d;
  logic          freeze_q, freeze_d;
  logic [3:0]    kp_q, kp_d;
  logic [3:0]    ki_q, ki_d;

  logic on_time;
  logic way_off;

  assign on_time = bus.error_valid && (bus.margin_zone == 2'b01);
  assign way_off = bus.error_valid && (bus.margin_zone == 2'b11);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    bad_d     = bad_q;
    miss_d    = miss_q;
    hold_d    = hold_q;
    atmr_d    = atmr_q;
    acq_cyc_d = acq_cyc_q;
    lacq_d    = 1'b0;
    llost_d   = 1'b0;
    if (!bus.enable) begin
      state_d = S_IDLE;
      good_d  = '0;
      bad_d   = '0;
      miss_d  = '0;
      hold_d  = '0;
      atmr_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ACQ;
          good_d  = '0;
          atmr_d  = '0;
          bad_d   = '0;
          miss_d  = '0;
        end
        S_ACQ: begin
          if (atmr_q != 16'hFFFF) atmr_d = atmr_q + 16'd1;
          if (on_time) begin
            good_d = good_q + 1'b1;
            if (good_q == GOOD_LAST) begin
              state_d   = S_TRK;
              lacq_d    = 1'b1;
              acq_cyc_d = (atmr_q == 16'hFFFF) ? 16'hFFFF
                                               : atmr_q + 16'd1;
              bad_d     = '0;
              miss_d    = '0;
            end
          end else if (bus.error_valid) begin
            good_d = '0;
          end
        end
        S_TRK: begin
          // An edge in the same cycle as a missing flag masks the flag.
          if (bus.error_valid) begin
            miss_d = '0;
            unique case (1'b1)
              way_off: begin
                bad_d = bad_q + 1'b1;
                if (bad_q == BAD_LAST) begin
                  state_d = S_ACQ;
                  llost_d = 1'b1;
                  good_d  = '0;
                  atmr_d  = '0;
                end
              end
              on_time: begin
                if (bad_q != '0) bad_d = bad_q - 1'b1;
              end
              default: ;
            endcase
          end else if (bus.missing_pulse) begin
            miss_d = miss_q + 1'b1;
            if (miss_q == MISS_LAST) begin
              state_d = S_HOLD;
              hold_d  = '0;
            end
          end
        end
        S_HOLD: begin
          hold_d = hold_q + 1'b1;
          if (on_time) begin
            state_d = S_TRK;
            miss_d  = '0;
          end else if (hold_q == HOLD_LAST) begin
            state_d = S_ACQ;
            llost_d = 1'b1;
            good_d  = '0;
            atmr_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    locked_d = state_d[1];
    freeze_d = (state_d == S_HOLD);
    kp_d     = state_d[1] ? 4'(TRK_KP_SHIFT) : 4'(ACQ_KP_SHIFT);
    ki_d     = state_d[1] ? 4'(TRK_KI_SHIFT) : 4'(ACQ_KI_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      good_q    <= '0;
      bad_q     <= '0;
      miss_q    <= '0;
      hold_q    <= '0;
      atmr_q    <= '0;
      acq_cyc_q <= '0;
      lacq_q    <= 1'b0;
      llost_q   <= 1'b0;
      locked_q  <= 1'b0;
      freeze_q  <= 1'b0;
      kp_q      <= 4'(ACQ_KP_SHIFT);
      ki_q      <= 4'(ACQ_KI_SHIFT);
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      miss_q    <= miss_d;
      hold_q    <= hold_d;
      atmr_q    <= atmr_d;
      acq_cyc_q <= acq_cyc_d;
      lacq_q    <= lacq_d;
      llost_q   <= llost_d;
      locked_q  <= locked_d;
      freeze_q  <= freeze_d;
      kp_q      <= kp_d;
      ki_q      <= ki_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.locked        = locked_q;
  assign bus.nco_freeze    = freeze_q;
  assign bus.kp_shift      = kp_q;
  assign bus.ki_shift      = ki_q;
  assign bus.lock_acquired = lacq_q;
  assign bus.lock_lost     = llost_q;
  assign bus.acq_cycles    = acq_cyc_q;

endmodule
